// File: rtl/alu_add_sequencer.sv
// -----------------------------------------------------------------------------
// alu_add_sequencer
//   Multi-cycle add/subtract controller for wide operands. A single 3-bit
//   adder slice is reused once per clock, least-significant digit first, with
//   the slice carry-out registered and fed back as the next carry-in.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request a new operation (sampled in IDLE only)
//   sub    in   1  0 = a+b, 1 = a-b (sampled with start)
//   a      in   W  operand A (sampled with start)
//   b      in   W  operand B (sampled with start)
//   busy   out  1  operation in progress
//   done   out  1  one-cycle pulse when sum/cout/ovf become valid
//   sum    out  W  result modulo 2^W
//   cout   out  1  final carry-out (for sub: 1 = no borrow)
//   ovf    out  1  signed two's-complement overflow
//
//   W = 3*DIGITS, DIGITS legal range 2..16.
// -----------------------------------------------------------------------------

// 3-bit adder slice: r[3] is the carry-out.
module adder (
  input  logic       cin,
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [3:0] r
);
  assign r = {1'b0, x} + {1'b0, y} + {3'b000, cin};
endmodule

module alu_add_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [3*DIGITS-1:0]   a,
  input  logic [3*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [3*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 3 * DIGITS;
  localparam int CW = $clog2(DIGITS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_a_msb;
  logic          r_b_msb;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;

  logic [3:0]    w_r;
  logic [W-1:0]  w_b_in;
  logic [W-1:0]  w_res_next;
  logic          w_last;

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
  assign w_b_in = sub ? ~b : b;

  // Current digit is shifted into the top; after DIGITS shifts the first
  // digit has reached bit 0, so this value is the full result on the last edge.
  assign w_res_next = {w_r[2:0], r_res[W-1:3]};
  assign w_last     = (r_cnt == CNT_LAST);

  adder u_adder (
    .cin (r_carry),
    .x   (r_a[2:0]),
    .y   (r_b[2:0]),
    .r   (w_r)
  );

  // Control FSM, digit datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_res   <= {W{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= {W{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= sub;
            r_cnt   <= {CW{1'b0}};
            r_res   <= {W{1'b0}};
            r_a_msb <= a[W-1];
            r_b_msb <= w_b_in[W-1];
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_carry <= w_r[3];
          r_res   <= w_res_next;
          r_a     <= {3'b000, r_a[W-1:3]};
          r_b     <= {3'b000, r_b[W-1:3]};
          r_cnt   <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_sum   <= w_res_next;
            r_cout  <= w_r[3];
            // Overflow: operands share a sign that the result does not.
            r_ovf   <= (r_a_msb == r_b_msb) && (w_r[2] != r_a_msb);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_add_sequencer
//   Directed self-checking bench for alu_add_sequencer with DIGITS=4 (W=12).
//   Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_add_sequencer;

  localparam int DIGITS = 4;
  localparam int W      = 3 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total;
  int bad;

  alu_add_sequencer #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, output bit got, output int n,
                        output logic [W-1:0] s, output logic c, output logic o);
    got = 1'b0;
    n   = 0;
    s   = '0;
    c   = 1'b0;
    o   = 1'b0;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1; n = k; s = sum; c = cout; o = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #22;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, cout, ovf} !== {(W+4){1'b0}}) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    a = 12'h0FF; b = 12'h001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      total++;
      if (busy !== (k <= 4)) begin
        bad++;
        $display("FAIL add_busy k=%0d: got %b want %b", k, busy, (k <= 4));
      end
      total++;
      if (done !== (k == 5)) begin
        bad++;
        $display("FAIL add_done k=%0d: got %b want %b", k, done, (k == 5));
      end
      if (k == 5) begin
        total++;
        if ({sum, cout, ovf} !== {12'h100, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL add_result: got sum=%h cout=%b ovf=%b want 100/0/0", sum, cout, ovf);
        end
      end
    end
  endtask

  task automatic test_carry();
    bit got; int n; logic [W-1:0] s; logic c; logic o;
    run_op(12'hFFF, 12'h001, 1'b0, got, n, s, c, o);
    total++;
    if (!got || {s, c, o} !== {12'h000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_cout: got done=%b sum=%h cout=%b ovf=%b want 000/1/0", got, s, c, o);
    end
    run_op(12'h7FF, 12'h001, 1'b0, got, n, s, c, o);
    total++;
    if (!got || {s, c, o} !== {12'h800, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_ovf: got done=%b sum=%h cout=%b ovf=%b want 800/0/1", got, s, c, o);
    end
  endtask

  task automatic test_sub();
    bit got; int n; logic [W-1:0] s; logic c; logic o;
    run_op(12'h005, 12'h007, 1'b1, got, n, s, c, o);
    total++;
    if (!got || {s, c, o} !== {12'hFFE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_borrow: got done=%b sum=%h cout=%b ovf=%b want FFE/0/0", got, s, c, o);
    end
    total++;
    if (n != DIGITS + 1) begin
      bad++;
      $display("FAIL sub_latency: got %0d want %0d", n, DIGITS + 1);
    end
    run_op(12'h800, 12'h001, 1'b1, got, n, s, c, o);
    total++;
    if (!got || {s, c, o} !== {12'h7FF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_ovf: got done=%b sum=%h cout=%b ovf=%b want 7FF/1/1", got, s, c, o);
    end
  endtask

  task automatic test_ignore_busy();
    int ndone;
    logic [W-1:0] cap;
    ndone = 0;
    cap   = '0;
    @(negedge clk);
    a = 12'h0FF; b = 12'h001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        cap = sum;
      end
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; a = 12'hFFF; b = 12'hFFF; sub = 1'b1; end
      if (k == 3) begin start = 1'b0; a = 12'h000; b = 12'h000; end
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL ignore_done_count: got %0d want 1", ndone);
    end
    total++;
    if (cap !== 12'h100) begin
      bad++;
      $display("FAIL ignore_result: got %h want 100", cap);
    end
    total++;
    if (sum !== 12'h100) begin
      bad++;
      $display("FAIL ignore_hold: got %h want 100", sum);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int pos[3];
    ndone = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    @(negedge clk);
    a = 12'h123; b = 12'h456; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (ndone < 3) pos[ndone] = k;
        ndone++;
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 3 || pos[0] != 5 || pos[1] != 11 || pos[2] != 17) begin
      bad++;
      $display("FAIL b2b_done_spacing: got n=%0d at %0d,%0d,%0d want 3 at 5,11,17",
               ndone, pos[0], pos[1], pos[2]);
    end
    total++;
    if (sum !== 12'h579) begin
      bad++;
      $display("FAIL b2b_result: got %h want 579", sum);
    end
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    bit got; int n; logic [W-1:0] s; logic c; logic o;
    ndone = 0;
    @(negedge clk);
    a = 12'h7FF; b = 12'h001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, cout, ovf} !== {(W+4){1'b0}}) begin
      bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL midreset_no_done: got %0d activity cycles want 0", ndone);
    end
    run_op(12'h123, 12'h456, 1'b0, got, n, s, c, o);
    total++;
    if (!got || {s, c, o} !== {12'h579, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_rerun: got done=%b sum=%h cout=%b ovf=%b want 579/0/0", got, s, c, o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
